// File: rtl/mpaddsub_iter.sv
// Wide add/sub that walks WORD bits per cycle with a registered carry; start/done handshake, busy blocks start.
// Latency NW cycles (1 cycle when MPADDSUB_SINGLE_CYCLE_EN is defined); start re-accepted in the done cycle.
module mpaddsub_iter #(
  parameter int WIDTH = 514,
  parameter int WORD  = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;

`ifdef MPADDSUB_SINGLE_CYCLE_EN
  logic [WIDTH:0] acc_q, acc_d;
  logic [WIDTH:0] full_sum;

  // Inverted B plus carry-in of one gives A-B modulo 2^(WIDTH+1).
  assign full_sum = {1'b0, in_a} + ({1'b0, in_b} ^ {(WIDTH+1){subtract}})
                  + {{WIDTH{1'b0}}, subtract};
  assign result   = acc_q;
`else
  localparam int NW  = (WIDTH + WORD) / WORD;
  localparam int TOT = NW * WORD;
  localparam int CW  = $clog2(NW + 1);

  logic [TOT-1:0]  acc_q, acc_d;
  logic [TOT-1:0]  a_q, a_d;
  logic [TOT-1:0]  b_q, b_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TOT-1:0]  a_ext, b_ext;
  logic [WORD:0]   word_sum;

  assign a_ext    = {{(TOT-WIDTH){1'b0}}, in_a};
  assign b_ext    = {{(TOT-WIDTH){1'b0}}, in_b} ^ {TOT{subtract}};
  assign word_sum = {1'b0, a_q[WORD-1:0]} + {1'b0, b_q[WORD-1:0]}
                  + {{WORD{1'b0}}, carry_q};
  // Once all NW words have been shifted in, the padded sum sits at bit 0; the top pad bits are dropped.
  assign result   = acc_q[WIDTH:0];
`endif

  assign done = done_q;
  assign busy = busy_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    acc_d   = acc_q;
`ifndef MPADDSUB_SINGLE_CYCLE_EN
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    count_d = count_q;
`endif
    case (state_q)
      ST_RUN: begin
`ifdef MPADDSUB_SINGLE_CYCLE_EN
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
`else
        acc_d   = {word_sum[WORD-1:0], acc_q[TOT-1:WORD]};
        a_d     = a_q >> WORD;
        b_d     = b_q >> WORD;
        carry_d = word_sum[WORD];
        count_d = count_q + 1'b1;
        if (count_q == CW'(NW - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          busy_d  = 1'b1;
          state_d = ST_RUN;
`ifdef MPADDSUB_SINGLE_CYCLE_EN
          acc_d   = full_sum;
`else
          a_d     = a_ext;
          b_d     = b_ext;
          carry_d = subtract;
          count_d = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      acc_q   <= '0;
`ifndef MPADDSUB_SINGLE_CYCLE_EN
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      acc_q   <= acc_d;
`ifndef MPADDSUB_SINGLE_CYCLE_EN
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      count_q <= count_d;
`endif
    end
  end

endmodule

// File: tb/tb_mpaddsub_iter.sv
// Bench for mpaddsub_iter: directed corner cases plus random operands against a plain-arithmetic model.
module tb_mpaddsub_iter;

  localparam int W  = 514;
  localparam int WD = 128;
`ifdef MPADDSUB_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = (W + WD) / WD;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic         subtract;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W:0]   result;
  logic         done;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  mpaddsub_iter #(.WIDTH(W), .WORD(WD)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] r;
    if (sub) r = {1'b0, a} - {1'b0, b};
    else     r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [575:0] t;
    int mode;
    for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
    mode = $urandom_range(0, 5);
    if (mode == 0) t = '1;
    else if (mode == 1) t = '0;
    else if (mode == 2) t = {544'd0, t[31:0]};
    return t[W-1:0];
  endfunction

  // Launches one operation from IDLE or DONE and waits (bounded) for done; inputs are scrambled while busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output int lat, output int bc, output logic [W:0] res);
    in_a = a; in_b = b; subtract = sub; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      in_a = rnd_op(); in_b = rnd_op(); subtract = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0;
    step(); step();
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [W-1:0] a, b;
    logic [W:0]   res, exp;
    int lat, bc;
    a = '1; b = 1;
    exp = '0; exp[W] = 1'b1;
    do_op(a, b, 1'b0, lat, bc, res);
    n_vec++; if (res !== exp) begin n_err++; $display("FAIL add_max result got %h want %h", res, exp); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL add_max latency got %0d want %0d", lat, LAT); end
    n_vec++; if (bc !== LAT) begin n_err++; $display("FAIL add_max busy_cycles got %0d want %0d", bc, LAT); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_max busy_at_done got %b want 0", busy); end
    step();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b want 0", done); end
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL result_hold got %h want %h", result, exp); end

    do_op(5, 3, 1'b1, lat, bc, res);
    exp = 2;
    n_vec++; if (res !== exp) begin n_err++; $display("FAIL sub_5_3 got %h want %h", res, exp); end
    n_vec++; if (res[W] !== 1'b0) begin n_err++; $display("FAIL sub_5_3 borrow got %b want 0", res[W]); end

    do_op(3, 5, 1'b1, lat, bc, res);
    exp = '1; exp[0] = 1'b0;
    n_vec++; if (res !== exp) begin n_err++; $display("FAIL sub_3_5 got %h want %h", res, exp); end
    n_vec++; if (res[W] !== 1'b1) begin n_err++; $display("FAIL sub_3_5 borrow got %b want 1", res[W]); end

    a = rnd_op();
    do_op(a, a, 1'b1, lat, bc, res);
    n_vec++; if (res !== '0) begin n_err++; $display("FAIL sub_equal got %h want 0", res); end

    a = '1;
    do_op(0, a, 1'b1, lat, bc, res);
    exp = model(0, a, 1'b1);
    n_vec++; if (res !== exp) begin n_err++; $display("FAIL sub_0_max got %h want %h", res, exp); end
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         sub;
    logic [W:0]   res, exp;
    int lat, bc;
    for (int i = 0; i < 24; i++) begin
      a = rnd_op(); b = rnd_op(); sub = 1'($urandom_range(0, 1));
      exp = model(a, b, sub);
      do_op(a, b, sub, lat, bc, res);
      n_vec++; if (res !== exp) begin n_err++; $display("FAIL random[%0d] sub=%b got %h want %h", i, sub, res, exp); end
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL random[%0d] latency got %0d want %0d", i, lat, LAT); end
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a1, b1;
    logic [W:0]   exp;
    int lat;
    a1 = rnd_op(); b1 = rnd_op();
    exp = model(a1, b1, 1'b0);
    in_a = a1; in_b = b1; subtract = 1'b0; start = 1'b1;
    step();
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      start = (lat == 2);
      in_a = rnd_op(); in_b = rnd_op(); subtract = ~subtract;
      step();
      lat++;
    end
    start = 1'b0;
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL ignore_start result got %h want %h", result, exp); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL ignore_start latency got %0d want %0d", lat, LAT); end
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_start idle_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [W:0]   e1, e2;
    int lat;
    a1 = rnd_op(); b1 = rnd_op(); a2 = rnd_op(); b2 = rnd_op();
    e1 = model(a1, b1, 1'b1);
    e2 = model(a2, b2, 1'b0);
    in_a = a1; in_b = b1; subtract = 1'b1; start = 1'b1;
    step();
    in_a = a2; in_b = b2; subtract = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin step(); lat++; end
    n_vec++; if (result !== e1) begin n_err++; $display("FAIL b2b_first result got %h want %h", result, e1); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_first latency got %0d want %0d", lat, LAT); end
    step();
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_reaccept busy got %b want 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin in_a = rnd_op(); step(); lat++; end
    n_vec++; if (result !== e2) begin n_err++; $display("FAIL b2b_second result got %h want %h", result, e2); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_second latency got %0d want %0d", lat, LAT); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b;
    logic [W:0]   res, exp;
    int lat, bc;
    logic saw_done;
    in_a = rnd_op() | 1; in_b = rnd_op(); subtract = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_mid busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_mid done got %b want 0", done); end
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_mid result got %h want 0", result); end
    step();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      step();
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL reset_mid spurious_done got %b want 0", saw_done); end
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_mid result_after got %h want 0", result); end
    a = rnd_op(); b = rnd_op();
    exp = model(a, b, 1'b0);
    do_op(a, b, 1'b0, lat, bc, res);
    n_vec++; if (res !== exp) begin n_err++; $display("FAIL reset_mid next_op got %h want %h", res, exp); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL reset_mid next_latency got %0d want %0d", lat, LAT); end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
